// File: rtl/quad_decoder.sv
// Quadrature rotary-encoder front end.
// Synchronises and debounces the A/B/push pins, decodes the A/B Gray sequence into
// direction-tagged step strobes and keeps a bounded position counter.
// Optional feature macro: QUAD_WRAP_EN. When defined, the position wraps at its bounds.
// When undefined (default), the position saturates.
// EDGES_PER_STEP must be 1, 2 or 4. The accumulator is 4 bits signed.

module quad_decoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned EDGES_PER_STEP  = 4,
   parameter int unsigned POS_WIDTH       = 8,
   parameter int unsigned POS_MIN         = 0,
   parameter int unsigned POS_MAX         = 255,
   parameter int unsigned POS_INIT        = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [2:0]           rot_i,
   output logic                 strobe_o,
   output logic                 dir_o,
   output logic [POS_WIDTH-1:0] pos_o,
   output logic                 err_o,
   output logic                 btn_o,
   output logic                 btn_press_o
);

   // The counter must hold DEBOUNCE_CYCLES+1, the last INIT count.
   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 2);

   localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] InitLast = CntW'(DEBOUNCE_CYCLES + 1);

   localparam logic signed [3:0] AccUp = 4'(EDGES_PER_STEP);
   localparam logic signed [3:0] AccDn = -AccUp;

   localparam logic [POS_WIDTH-1:0] PosMin  = POS_WIDTH'(POS_MIN);
   localparam logic [POS_WIDTH-1:0] PosMax  = POS_WIDTH'(POS_MAX);
   localparam logic [POS_WIDTH-1:0] PosInit = POS_WIDTH'(POS_INIT);

   typedef enum logic [0:0] {
      StInit,
      StRun
   } state_e;

   state_e                     state_q, state_d;
   logic [CntW-1:0]            init_cnt_q, init_cnt_d;

   logic [2:0]                 sync1_q, sync2_q;
   logic [2:0]                 deb_q, deb_d;
   logic [2:0][CntW-1:0]       deb_cnt_q, deb_cnt_d;

   logic [1:0]                 prev_ab_q, prev_ab_d;
   logic signed [3:0]          acc_q, acc_d;
   logic                       strobe_q, strobe_d;
   logic                       dir_q, dir_d;
   logic                       err_q, err_d;
   logic [POS_WIDTH-1:0]       pos_q, pos_d;
   logic                       btn_prev_q, btn_prev_d;
   logic                       btn_press_q, btn_press_d;

   // Position along the CW sequence 00->01->11->10. The result is {B, A^B}.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   // Debounce each pin. In INIT the synced value is taken directly.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         if (state_q == StInit) begin
            deb_d[i] = sync2_q[i];
         end else if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == DebLast) begin
               deb_d[i] = sync2_q[i];
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   // Decoder FSM: INIT settles the debouncers, RUN decodes edges into steps.
   always_comb begin
      logic [1:0]        diff;
      logic signed [3:0] acc_next;

      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      prev_ab_d   = prev_ab_q;
      acc_d       = acc_q;
      strobe_d    = 1'b0;
      dir_d       = dir_q;
      err_d       = 1'b0;
      pos_d       = pos_q;
      btn_prev_d  = deb_q[2];
      btn_press_d = 1'b0;
      diff        = gray_idx(deb_q[1:0]) - gray_idx(prev_ab_q);
      acc_next    = acc_q;

      unique case (state_q)
         StInit: begin
            init_cnt_d = init_cnt_q + CntW'(1);
            // Track the next debounced value so the first RUN cycle sees no edge.
            prev_ab_d  = deb_d[1:0];
            btn_prev_d = deb_d[2];
            if (init_cnt_q == InitLast) begin
               init_cnt_d = '0;
               state_d    = StRun;
            end
         end

         StRun: begin
            prev_ab_d   = deb_q[1:0];
            btn_press_d = deb_q[2] & ~btn_prev_q;

            unique case (diff)
               2'd1:    acc_next = acc_q + 4'sd1;
               2'd3:    acc_next = acc_q - 4'sd1;
               2'd2:    err_d    = 1'b1;
               default: acc_next = acc_q;
            endcase
            acc_d = acc_next;

            if (acc_next == AccUp) begin
               acc_d    = '0;
               strobe_d = 1'b1;
               dir_d    = 1'b1;
               if (pos_q == PosMax) begin
`ifdef QUAD_WRAP_EN
                  pos_d = PosMin;
`else
                  pos_d = PosMax;
`endif
               end else begin
                  pos_d = pos_q + POS_WIDTH'(1);
               end
            end else if (acc_next == AccDn) begin
               acc_d    = '0;
               strobe_d = 1'b1;
               dir_d    = 1'b0;
               if (pos_q == PosMin) begin
`ifdef QUAD_WRAP_EN
                  pos_d = PosMax;
`else
                  pos_d = PosMin;
`endif
               end else begin
                  pos_d = pos_q - POS_WIDTH'(1);
               end
            end
         end

         default: state_d = StInit;
      endcase
   end

   // Synchroniser chain and all state, with a synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         deb_q       <= '0;
         deb_cnt_q   <= '0;
         state_q     <= StInit;
         init_cnt_q  <= '0;
         prev_ab_q   <= '0;
         acc_q       <= '0;
         strobe_q    <= 1'b0;
         dir_q       <= 1'b0;
         err_q       <= 1'b0;
         pos_q       <= PosInit;
         btn_prev_q  <= 1'b0;
         btn_press_q <= 1'b0;
      end else begin
         sync1_q     <= rot_i;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         prev_ab_q   <= prev_ab_d;
         acc_q       <= acc_d;
         strobe_q    <= strobe_d;
         dir_q       <= dir_d;
         err_q       <= err_d;
         pos_q       <= pos_d;
         btn_prev_q  <= btn_prev_d;
         btn_press_q <= btn_press_d;
      end
   end

   assign strobe_o    = strobe_q;
   assign dir_o       = dir_q;
   assign pos_o       = pos_q;
   assign err_o       = err_q;
   assign btn_o       = deb_q[2];
   assign btn_press_o = btn_press_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder.
// A small encoder model pushes expected pulses, with their due cycle, into a queue.
// A negedge monitor pops and checks an entry whenever the DUT pulses an output.

module tb_quad_decoder;

   localparam int unsigned D     = 4;
   localparam int unsigned E     = 4;
   localparam int unsigned PW    = 3;
   localparam int unsigned PMIN  = 0;
   localparam int unsigned PMAX  = 7;
   localparam int unsigned PINIT = 3;
   localparam int          Ph    = 20;
`ifdef QUAD_WRAP_EN
   localparam bit Wrap = 1'b1;
`else
   localparam bit Wrap = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    rot = 3'b011;
   logic          strobe, dir, err, btn, btn_press;
   logic [PW-1:0] pos;

   always #5 clk = ~clk;

   quad_decoder #(
      .DEBOUNCE_CYCLES(D),
      .EDGES_PER_STEP (E),
      .POS_WIDTH      (PW),
      .POS_MIN        (PMIN),
      .POS_MAX        (PMAX),
      .POS_INIT       (PINIT)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .rot_i      (rot),
      .strobe_o   (strobe),
      .dir_o      (dir),
      .pos_o      (pos),
      .err_o      (err),
      .btn_o      (btn),
      .btn_press_o(btn_press)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   // kind: 0 = strobe, 1 = err, 2 = btn_press
   typedef struct {
      int            kind;
      int            due;
      logic          dir;
      logic [PW-1:0] pos;
   } evt_t;
   evt_t evq[$];

   logic [1:0] m_ab;
   int         m_acc;
   int         m_pos;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [1:0] gidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         2'b11:   return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   task automatic push(input int kind, input logic d, input int p);
      evt_t e;
      e.kind = kind;
      e.due  = cyc + int'(D) + 3;
      e.dir  = d;
      e.pos  = PW'(p);
      evq.push_back(e);
   endtask

   // Drive a new {B,A}, update the model, then hold for the given cycles.
   task automatic drive_ab(input logic [1:0] ab, input int hold);
      logic [1:0] d;
      d = gidx(ab) - gidx(m_ab);
      rot[1:0] = ab;
      case (d)
         2'd1:    m_acc++;
         2'd3:    m_acc--;
         2'd2:    push(1, 1'b0, 0);
         default: ;
      endcase
      if (m_acc == int'(E)) begin
         m_acc = 0;
         if (m_pos == int'(PMAX)) m_pos = Wrap ? int'(PMIN) : int'(PMAX);
         else                     m_pos = m_pos + 1;
         push(0, 1'b1, m_pos);
      end else if (m_acc == -int'(E)) begin
         m_acc = 0;
         if (m_pos == int'(PMIN)) m_pos = Wrap ? int'(PMAX) : int'(PMIN);
         else                     m_pos = m_pos - 1;
         push(0, 1'b0, m_pos);
      end
      m_ab = ab;
      repeat (hold) @(negedge clk);
   endtask

   task automatic cw_cycle();
      // Starting from 11: 11->10->00->01->11
      drive_ab(2'b10, Ph);
      drive_ab(2'b00, Ph);
      drive_ab(2'b01, Ph);
      drive_ab(2'b11, Ph);
   endtask

   task automatic match(input int kind);
      evt_t e;
      chk("event_expected", 32'(evq.size() != 0), 32'd1);
      if (evq.size() != 0) begin
         e = evq.pop_front();
         chk("event_kind", 32'(kind), 32'(e.kind));
         chk("event_cycle", 32'(cyc), 32'(e.due));
         if (kind == 0) begin
            chk("strobe_dir", 32'(dir), 32'(e.dir));
            chk("strobe_pos", 32'(pos), 32'(e.pos));
         end
      end
   endtask

   // Scoreboard: every output pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (strobe === 1'b1)    match(0);
      if (err === 1'b1)       match(1);
      if (btn_press === 1'b1) match(2);
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_strobe"}, 32'(strobe), 32'd0);
      chk({tag, "_dir"}, 32'(dir), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_btn_press"}, 32'(btn_press), 32'd0);
      chk({tag, "_btn"}, 32'(btn), 32'd0);
      chk({tag, "_pos"}, 32'(pos), 32'(PINIT));
   endtask

   initial begin
      m_ab  = 2'b11;
      m_acc = 0;
      m_pos = int'(PINIT);

      // 1: reset with pins at 011, INIT must stay silent, then one CW step.
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      repeat (int'(D) + 2 + 10) @(negedge clk);
      chk("after_init_pos", 32'(pos), 32'(PINIT));
      cw_cycle();
      chk("cw_pos", 32'(pos), 32'(m_pos));
      chk("cw_dir", 32'(dir), 32'd1);

      // 2: two full CCW cycles.
      repeat (2) begin
         drive_ab(2'b01, Ph);
         drive_ab(2'b00, Ph);
         drive_ab(2'b10, Ph);
         drive_ab(2'b11, Ph);
      end
      chk("ccw_pos", 32'(pos), 32'(m_pos));
      chk("ccw_dir", 32'(dir), 32'd0);

      // 3: bounce on A faster than the debounce window; the model expects nothing.
      for (int i = 0; i < 15; i++) begin
         rot[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) @(negedge clk);
      end
      rot[0] = 1'b1;
      repeat (Ph) @(negedge clk);
      chk("bounce_pos", 32'(pos), 32'(m_pos));

      // 4: half step forward and back, then a full step proves the accumulator is at 0.
      drive_ab(2'b10, Ph);
      drive_ab(2'b00, Ph);
      drive_ab(2'b10, Ph);
      drive_ab(2'b11, Ph);
      chk("half_step_pos", 32'(pos), 32'(m_pos));
      cw_cycle();
      chk("after_half_pos", 32'(pos), 32'(m_pos));

      // 5: run up to POS_MAX, then one more CW step at the bound.
      while (m_pos != int'(PMAX)) cw_cycle();
      chk("at_max_pos", 32'(pos), 32'(PMAX));
      cw_cycle();
      chk("bound_pos", 32'(pos), Wrap ? 32'(PMIN) : 32'(PMAX));
      chk("bound_dir", 32'(dir), 32'd1);

      // 6: reach 00, then jump straight to 11.
      drive_ab(2'b10, Ph);
      drive_ab(2'b00, Ph);
      drive_ab(2'b11, Ph);
      chk("illegal_pos", 32'(pos), 32'(m_pos));

      // 7: push pressed for 10 cycles, then released.
      rot[2] = 1'b1;
      push(2, 1'b0, 0);
      repeat (10) @(negedge clk);
      chk("btn_level_high", 32'(btn), 32'd1);
      rot[2] = 1'b0;
      repeat (Ph) @(negedge clk);
      chk("btn_level_low", 32'(btn), 32'd0);

      // 8: reset mid-step discards the partial step.
      drive_ab(2'b10, Ph);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_reset");
      rst   = 1'b0;
      m_acc = 0;
      m_pos = int'(PINIT);
      repeat (int'(D) + 2 + 10) @(negedge clk);
      drive_ab(2'b00, Ph);
      drive_ab(2'b01, Ph);
      drive_ab(2'b11, Ph);
      drive_ab(2'b10, Ph);
      chk("post_reset_pos", 32'(pos), 32'(m_pos));
      chk("post_reset_dir", 32'(dir), 32'd1);

      repeat (Ph) @(negedge clk);
      chk("events_outstanding", 32'(evq.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
